// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: controller state encoding, geometry constants and mux selects.
package lc3b_types;

    localparam int unsigned CACHE_SETS    = 8;
    localparam int unsigned CACHE_INDEX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_t;

    localparam logic DATA_SEL_PMEM   = 1'b0;
    localparam logic DATA_SEL_CPU    = 1'b1;
    localparam logic ADDR_SEL_CPU    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;
    localparam logic WAY_ONE         = 1'b0;
    localparam logic WAY_TWO         = 1'b1;

endpackage

// File: rtl/cache_lru_array.sv
// Per-set LRU bit storage: one write port, combinational read, async active-low reset.
module cache_lru_array
    import lc3b_types::*;
#(
    parameter int unsigned NUM_SETS = CACHE_SETS,
    parameter int unsigned INDEX_W  = CACHE_INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] idx_i,
    input  logic               bit_i,
    output logic               bit_o
);

    logic [NUM_SETS-1:0] lru_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (we_i) begin
            lru_q[idx_i] <= bit_i;
        end
    end

    assign bit_o = lru_q[idx_i];

endmodule

// File: rtl/cache_control.sv
// 2-way set-associative cache sequencer: hit service, writeback/fill, LRU victim choice.
// Optional hit/miss counters are enabled with `define CACHE_CTRL_STATS_EN.
module cache_control
    import lc3b_types::*;
#(
    parameter int unsigned NUM_SETS = CACHE_SETS,
    parameter int unsigned INDEX_W  = CACHE_INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               mem_resp,
    input  logic [INDEX_W-1:0] index,
    input  logic               way_one_hit,
    input  logic               way_two_hit,
    input  logic               way_one_valid,
    input  logic               way_two_valid,
    input  logic               way_one_dirty,
    input  logic               way_two_dirty,
    output logic               load_way_one,
    output logic               load_way_two,
    output logic               dirty_in,
    output logic               data_sel,
    output logic               pmem_addr_sel,
    output logic               victim_way,
    output logic               pmem_read,
    output logic               pmem_write,
    input  logic               pmem_resp
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    cache_state_t state_q, state_d;
    logic         victim_q, victim_d;
    logic         lru_bit, lru_we, lru_wdata;
    logic         req, hit, victim_sel, victim_wb;

    cache_lru_array #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W)
    ) u_lru (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (lru_we),
        .idx_i (index),
        .bit_i (lru_wdata),
        .bit_o (lru_bit)
    );

    assign req = mem_read | mem_write;
    assign hit = way_one_hit | way_two_hit;

    // Invalid ways are always preferred over the LRU choice.
    always_comb begin
        victim_sel = lru_bit;
        if (!way_one_valid) begin
            victim_sel = WAY_ONE;
        end else if (!way_two_valid) begin
            victim_sel = WAY_TWO;
        end
        victim_wb = (victim_sel == WAY_TWO) ? (way_two_valid & way_two_dirty)
                                            : (way_one_valid & way_one_dirty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= WAY_ONE;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        mem_resp      = 1'b0;
        load_way_one  = 1'b0;
        load_way_two  = 1'b0;
        dirty_in      = 1'b0;
        data_sel      = DATA_SEL_PMEM;
        pmem_addr_sel = ADDR_SEL_CPU;
        victim_way    = WAY_ONE;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        lru_we        = 1'b0;
        lru_wdata     = WAY_ONE;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    mem_resp  = 1'b1;
                    lru_we    = 1'b1;
                    lru_wdata = way_one_hit ? WAY_TWO : WAY_ONE;
                    if (mem_write) begin
                        load_way_one = way_one_hit;
                        load_way_two = !way_one_hit;
                        data_sel     = DATA_SEL_CPU;
                        dirty_in     = 1'b1;
                    end
                end else if (req) begin
                    victim_d = victim_sel;
                    state_d  = victim_wb ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = ADDR_SEL_VICTIM;
                victim_way    = victim_q;
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = ADDR_SEL_CPU;
                victim_way    = victim_q;
                if (pmem_resp) begin
                    load_way_one = (victim_q == WAY_ONE);
                    load_way_two = (victim_q == WAY_TWO);
                    data_sel     = DATA_SEL_PMEM;
                    dirty_in     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;
    logic        missed_q;

    // missed_q marks a request that left IDLE so its final re-lookup is not a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            missed_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d != IDLE) begin
                miss_count_q <= miss_count_q + 16'd1;
                missed_q     <= 1'b1;
            end
            if (mem_resp) begin
                missed_q <= 1'b0;
                if (!missed_q) begin
                    hit_count_q <= hit_count_q + 16'd1;
                end
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Randomized scoreboard bench for cache_control with a datapath/pmem environment model.
// Also checks the hit/miss counters when built with CACHE_CTRL_STATS_EN.
module tb_cache_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_read, mem_write, mem_resp;
    logic [2:0] index;
    logic       way_one_hit, way_two_hit, way_one_valid, way_two_valid;
    logic       way_one_dirty, way_two_dirty;
    logic       load_way_one, load_way_two, dirty_in, data_sel;
    logic       pmem_addr_sel, victim_way, pmem_read, pmem_write;
    logic       pmem_resp = 1'b0;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_control #(.NUM_SETS(8), .INDEX_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .index         (index),
        .way_one_hit   (way_one_hit),
        .way_two_hit   (way_two_hit),
        .way_one_valid (way_one_valid),
        .way_two_valid (way_two_valid),
        .way_one_dirty (way_one_dirty),
        .way_two_dirty (way_two_dirty),
        .load_way_one  (load_way_one),
        .load_way_two  (load_way_two),
        .dirty_in      (dirty_in),
        .data_sel      (data_sel),
        .pmem_addr_sel (pmem_addr_sel),
        .victim_way    (victim_way),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Datapath environment: tag/valid/dirty storage written by the DUT's load strobes.
    logic env_v [2][8];
    logic env_d [2][8];
    int   env_t [2][8];
    int   cur_tag = 0;
    logic env_clear = 1'b1;

    always_comb begin
        way_one_valid = env_v[0][index];
        way_two_valid = env_v[1][index];
        way_one_dirty = env_d[0][index];
        way_two_dirty = env_d[1][index];
        way_one_hit   = env_v[0][index] && (env_t[0][index] == cur_tag);
        way_two_hit   = env_v[1][index] && (env_t[1][index] == cur_tag);
    end

    always @(posedge clk) begin
        if (env_clear) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 8; s++) begin
                    env_v[w][s] <= 1'b0;
                    env_d[w][s] <= 1'b0;
                    env_t[w][s] <= 0;
                end
        end else if (rst_n) begin
            if (load_way_one) begin
                env_v[0][index] <= 1'b1;
                env_t[0][index] <= cur_tag;
                env_d[0][index] <= dirty_in;
            end
            if (load_way_two) begin
                env_v[1][index] <= 1'b1;
                env_t[1][index] <= cur_tag;
                env_d[1][index] <= dirty_in;
            end
        end
    end

    // Physical memory: responds after wb_lat/fill_lat command cycles and needs one
    // recovery cycle after a response before it starts timing the next command.
    int wb_lat = 1;
    int fill_lat = 1;
    int pcnt = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pmem_resp = 1'b0;
            pcnt = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            pcnt = 0;
        end else if (pmem_write || pmem_read) begin
            pcnt++;
            if (pcnt == (pmem_write ? wb_lat : fill_lat)) pmem_resp = 1'b1;
        end else begin
            pcnt = 0;
        end
    end

    typedef struct {
        bit hit;
        bit wb;
        bit way;
        bit wr;
        int lat;
    } exp_t;

    exp_t q[$];

    // Reference cache: which lines are held, dirty state, and the way to evict next.
    bit       rv [2][8];
    bit       rd [2][8];
    int       rt [2][8];
    bit       rvict [8];
    bit [15:0] m_hits = 0;
    bit [15:0] m_misses = 0;

    function automatic exp_t predict(input int tag, input int idx, input bit wr, input int wl, input int fl);
        exp_t e;
        e.wr = wr;
        e.wb = 1'b0;
        if (rv[0][idx] && rt[0][idx] == tag) begin
            e.hit = 1'b1; e.way = 1'b0; e.lat = 1;
        end else if (rv[1][idx] && rt[1][idx] == tag) begin
            e.hit = 1'b1; e.way = 1'b1; e.lat = 1;
        end else begin
            e.hit = 1'b0;
            if (!rv[0][idx])      e.way = 1'b0;
            else if (!rv[1][idx]) e.way = 1'b1;
            else                  e.way = rvict[idx];
            e.wb  = rv[e.way][idx] && rd[e.way][idx];
            e.lat = e.wb ? (wl + fl + 3) : (fl + 2);
        end
        return e;
    endfunction

    function automatic void commit(input int tag, input int idx, input exp_t e);
        rv[e.way][idx] = 1'b1;
        rt[e.way][idx] = tag;
        if (!e.hit) rd[e.way][idx] = 1'b0;
        if (e.wr) rd[e.way][idx] = 1'b1;
        rvict[idx] = ~e.way;
        if (e.hit) m_hits++;
        else m_misses++;
    endfunction

    // Monitor: times each request and pops the scoreboard on every mem_resp.
    int   cyc = 0;
    bit   wb_seen = 0, fill_seen = 0;
    int   wb_victim = 0, wb_addr = 0, fill_way = 0, fill_dirty = 0, fill_addr = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; wb_seen = 0; fill_seen = 0;
        end else if (mem_read || mem_write) begin
            cyc++;
            if (pmem_write && !wb_seen) begin
                wb_seen = 1; wb_victim = victim_way; wb_addr = pmem_addr_sel;
            end
            if ((load_way_one || load_way_two) && !data_sel) begin
                fill_seen = 1; fill_way = load_way_two; fill_dirty = dirty_in;
                fill_addr = pmem_addr_sel;
            end
            if (mem_resp) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    me = q.pop_front();
                    chk("latency", cyc, me.lat);
                    chk("writeback", wb_seen, me.wb);
                    if (me.wb) begin
                        chk("wb_victim", wb_victim, me.way);
                        chk("wb_addr_sel", wb_addr, 1);
                    end
                    chk("fill", fill_seen, !me.hit);
                    if (!me.hit) begin
                        chk("fill_way", fill_way, me.way);
                        chk("fill_dirty_in", fill_dirty, 0);
                        chk("fill_addr_sel", fill_addr, 0);
                    end
                    chk("resp_load_one", load_way_one, me.wr && me.way == 1'b0);
                    chk("resp_load_two", load_way_two, me.wr && me.way == 1'b1);
                    if (me.wr) begin
                        chk("resp_data_sel", data_sel, 1);
                        chk("resp_dirty_in", dirty_in, 1);
                    end
                end
                cyc = 0; wb_seen = 0; fill_seen = 0;
            end
        end
    end

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // op: 0 = read, 1 = write, 2 = read and write together (acts as a write)
    task automatic do_txn(input int tag, input int idx, input int op, input int wl, input int fl);
        exp_t e;
        bit   got;
        e = predict(tag, idx, op != 0, wl, fl);
        q.push_back(e);
        wb_lat = wl; fill_lat = fl;
        cur_tag = tag; index = 3'(idx);
        mem_read = (op != 1); mem_write = (op != 0);
        got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_resp) begin got = 1; break; end
        end
        if (!got) begin
            chk("resp_timeout", 0, 1);
            finish_run();
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        commit(tag, idx, e);
    endtask

    initial begin
        bit got;
        mem_read = 0; mem_write = 0; index = 0;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                rv[w][s] = 0; rd[w][s] = 0; rt[w][s] = 0;
            end
        for (int s = 0; s < 8; s++) rvict[s] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_resp, load_way_one, load_way_two, dirty_in, data_sel,
                              pmem_addr_sel, victim_way, pmem_read, pmem_write}, 0);
        env_clear = 0; rst_n = 1;
        @(posedge clk); #1;

        do_txn(1, 0, 0, 1, 3);   // cold read 0x0040: fill way one
        do_txn(2, 0, 0, 1, 2);   // 0x0080: fill way two
        do_txn(1, 0, 0, 1, 1);   // reread 0x0040: hit
        do_txn(1, 0, 1, 1, 1);   // write hit 0x0040: dirty way one
        do_txn(2, 0, 0, 1, 1);   // touch way two so way one is LRU
        do_txn(3, 0, 0, 3, 2);   // 0x00C0: dirty writeback of way one, then fill
        do_txn(1, 0, 2, 2, 1);   // read+write together on a miss behaves as a write

        @(negedge clk);
        chk("idle_outputs", {mem_resp, load_way_one, load_way_two, dirty_in, data_sel,
                             pmem_addr_sel, victim_way, pmem_read, pmem_write}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++)
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(1, 4), $urandom_range(1, 4));

        // Reset while filling a fresh set: pmem_read drops at once and nothing is loaded.
        cur_tag = 9; index = 3'd5; fill_lat = 50; wb_lat = 1; mem_read = 1;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (pmem_read) begin got = 1; break; end
        end
        chk("reach_fill", got, 1);
        #2;
        rst_n = 0; mem_read = 0;
        #1;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_loads", {load_way_one, load_way_two, mem_resp}, 0);
        @(posedge clk); #3;
        rst_n = 1;
        for (int s = 0; s < 8; s++) rvict[s] = 0;
        m_hits = 0; m_misses = 0;
        @(posedge clk); #1;

        do_txn(9, 5, 0, 1, 2);
        for (int s = 0; s < 4; s++) do_txn(7, s, 0, 2, 1);
        do_txn(7, 0, 1, 1, 1);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
`ifdef CACHE_CTRL_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
        finish_run();
    end

endmodule
